// File: rtl/round_sequencer_pkg.sv
// ============================================================================
// round_sequencer_pkg : state, result and peer-verdict codes for round flow
// Rev 1.0
// ============================================================================
`default_nettype none

package round_sequencer_pkg;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_WAIT_PEER = 4'd1,
    ST_LOAD      = 4'd2,
    ST_ANSWER    = 4'd3,
    ST_CHECK     = 4'd4,
    ST_RESULT    = 4'd5,
    ST_GAME_OVER = 4'd6
  } state_t;

  localparam logic [1:0] c_res_none    = 2'b00;
  localparam logic [1:0] c_res_correct = 2'b01;
  localparam logic [1:0] c_res_lost    = 2'b10;
  localparam logic [1:0] c_res_draw    = 2'b11;

  localparam logic [1:0] c_peer_none    = 2'b00;
  localparam logic [1:0] c_peer_correct = 2'b01;
  localparam logic [1:0] c_peer_wrong   = 2'b10;

  function automatic logic [3:0] hp_dec(input logic [3:0] hp);
    return (hp == 4'd0) ? 4'd0 : hp - 4'd1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/round_sequencer_if.sv
// ============================================================================
// round_sequencer_if : button/checker/GPIO/question-DB signals of one board
// Rev 1.0
// ============================================================================
`default_nettype none

interface round_sequencer_if;
  logic       ready_in;
  logic       peer_ready_in;
  logic [1:0] peer_result_in;
  logic       q_valid;
  logic       dec_in;
  logic       correct_in;
  logic       wrong_in;
  logic       ready_out;
  logic [1:0] result_out;
  logic       q_load;
  logic       input_en;
  logic       input_clr;
  logic [3:0] state;
  logic [3:0] hp;
  logic [7:0] time_left;

  modport master (
    input  ready_in, peer_ready_in, peer_result_in, q_valid, dec_in, correct_in, wrong_in,
    output ready_out, result_out, q_load, input_en, input_clr, state, hp, time_left
  );

  modport slave (
    output ready_in, peer_ready_in, peer_result_in, q_valid, dec_in, correct_in, wrong_in,
    input  ready_out, result_out, q_load, input_en, input_clr, state, hp, time_left
  );
endinterface

`default_nettype wire

// File: rtl/round_sequencer_sec_timer.sv
// ============================================================================
// round_sequencer_sec_timer : 1 s tick divider with loadable seconds down-counter
// Rev 1.0
// ============================================================================
`default_nettype none

module round_sequencer_sec_timer #(
  parameter int TICK_DIV = 50000000,
  parameter int CNT_W    = 8
) (
  input  wire logic             clk,
  input  wire logic             rst_n,
  input  wire logic             i_load,
  input  wire logic [CNT_W-1:0] i_load_val,
  input  wire logic             i_run,
  output logic      [CNT_W-1:0] o_count,
  output logic                  o_zero
);

  localparam int              TICK_W     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TICK_W-1:0] c_tick_max = TICK_W'(TICK_DIV - 1);

  logic [TICK_W-1:0] r_tick;
  logic [CNT_W-1:0]  r_count;

  // Loading restarts the sub-second phase so every reload gives full seconds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tick  <= '0;
      r_count <= '0;
    end else if (i_load) begin
      r_tick  <= '0;
      r_count <= i_load_val;
    end else if (i_run) begin
      if (r_tick == c_tick_max) begin
        r_tick <= '0;
        if (r_count != '0) r_count <= r_count - 1'b1;
      end else begin
        r_tick <= r_tick + 1'b1;
      end
    end
  end

  assign o_count = r_count;
  assign o_zero  = (r_count == '0);

endmodule

`default_nettype wire

// File: rtl/round_sequencer.sv
// ============================================================================
// round_sequencer : one game round - peer handshake, question fetch, timed answer, HP
// Rev 1.0
// ============================================================================
`default_nettype none

module round_sequencer
  import round_sequencer_pkg::*;
#(
  parameter int TICK_DIV   = 50000000,
  parameter int ANSWER_SEC = 30,
  parameter int RESULT_SEC = 3,
  parameter int HP_INIT    = 5
) (
  input wire logic          clk,
  input wire logic          rst_n,
  round_sequencer_if.master bus
);

  logic       r_peer_ready_s1, r_peer_ready_s2;
  logic [1:0] r_peer_result_s1, r_peer_result_s2;

  state_t     r_state;
  logic       r_ready_out;
  logic [1:0] r_result_out;
  logic       r_q_load;
  logic       r_input_en;
  logic       r_input_clr;
  logic [3:0] r_hp;

  logic       w_tmr_load;
  logic [7:0] w_tmr_val;
  logic       w_tmr_run;
  logic [7:0] w_tmr_count;
  logic       w_tmr_zero;

  logic       w_in_round;
  logic       w_peer_win;
  logic       w_lost;
  logic       w_correct;
  logic       w_wrong;
  logic [3:0] w_hp_next;
  logic       w_hp_empty;
  logic       w_enter_result;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_peer_ready_s1  <= 1'b0;
      r_peer_ready_s2  <= 1'b0;
      r_peer_result_s1 <= c_peer_none;
      r_peer_result_s2 <= c_peer_none;
    end else begin
      r_peer_ready_s1  <= bus.peer_ready_in;
      r_peer_ready_s2  <= r_peer_ready_s1;
      r_peer_result_s1 <= bus.peer_result_in;
      r_peer_result_s2 <= r_peer_result_s1;
    end
  end

  assign w_in_round = (r_state == ST_ANSWER) || (r_state == ST_CHECK);
  assign w_peer_win = (r_peer_result_s2 == c_peer_correct);
  assign w_lost     = w_in_round && (w_peer_win || w_tmr_zero);
  assign w_correct  = (r_state == ST_CHECK) && bus.correct_in;
  assign w_wrong    = (r_state == ST_CHECK) && bus.wrong_in;
  assign w_hp_next  = hp_dec(r_hp);
  assign w_hp_empty = (w_hp_next == 4'd0);

  // A correct verdict always reaches RESULT; a loss does unless it drains HP.
  assign w_enter_result = w_correct || (w_lost && !w_hp_empty);

  assign w_tmr_load = (r_state == ST_LOAD) || w_enter_result;
  assign w_tmr_val  = (r_state == ST_LOAD) ? 8'(ANSWER_SEC) : 8'(RESULT_SEC);
  assign w_tmr_run  = w_in_round || (r_state == ST_RESULT);

  round_sequencer_sec_timer #(
    .TICK_DIV (TICK_DIV),
    .CNT_W    (8)
  ) u_sec_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_tmr_load),
    .i_load_val (w_tmr_val),
    .i_run      (w_tmr_run),
    .o_count    (w_tmr_count),
    .o_zero     (w_tmr_zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_ready_out  <= 1'b0;
      r_result_out <= c_res_none;
      r_q_load     <= 1'b0;
      r_input_en   <= 1'b0;
      r_input_clr  <= 1'b0;
      r_hp         <= 4'(HP_INIT);
    end else begin
      r_q_load    <= 1'b0;
      r_input_clr <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_result_out <= c_res_none;
          r_input_en   <= 1'b0;
          r_ready_out  <= bus.ready_in;
          if (bus.ready_in) r_state <= ST_WAIT_PEER;
        end
        ST_WAIT_PEER: begin
          if (r_peer_ready_s2) begin
            r_state     <= ST_LOAD;
            r_q_load    <= 1'b1;
            r_input_clr <= 1'b1;
          end
        end
        ST_LOAD: begin
          if (bus.q_valid) begin
            r_state    <= ST_ANSWER;
            r_input_en <= 1'b1;
          end
        end
        ST_ANSWER, ST_CHECK: begin
          // Correct beats timeout; wrong plus peer win still costs a single HP.
          if (w_correct) begin
            r_state      <= ST_RESULT;
            r_ready_out  <= 1'b0;
            r_input_en   <= 1'b0;
            r_result_out <= w_peer_win ? c_res_draw : c_res_correct;
          end else if (w_lost || w_wrong) begin
            r_hp <= w_hp_next;
            if (w_hp_empty || w_lost) begin
              r_state      <= w_hp_empty ? ST_GAME_OVER : ST_RESULT;
              r_ready_out  <= 1'b0;
              r_input_en   <= 1'b0;
              r_result_out <= c_res_lost;
            end else begin
              r_state     <= ST_ANSWER;
              r_input_en  <= 1'b1;
              r_input_clr <= 1'b1;
            end
          end else if ((r_state == ST_ANSWER) && bus.dec_in) begin
            r_state    <= ST_CHECK;
            r_input_en <= 1'b0;
          end
        end
        ST_RESULT: begin
          r_ready_out <= 1'b0;
          r_input_en  <= 1'b0;
          if (w_tmr_zero) begin
            r_state      <= ST_IDLE;
            r_result_out <= c_res_none;
          end
        end
        ST_GAME_OVER: begin
          r_ready_out  <= 1'b0;
          r_input_en   <= 1'b0;
          r_result_out <= c_res_lost;
        end
        default: begin
          r_state      <= ST_IDLE;
          r_ready_out  <= 1'b0;
          r_input_en   <= 1'b0;
          r_result_out <= c_res_none;
        end
      endcase
    end
  end

  assign bus.ready_out  = r_ready_out;
  assign bus.result_out = r_result_out;
  assign bus.q_load     = r_q_load;
  assign bus.input_en   = r_input_en;
  assign bus.input_clr  = r_input_clr;
  assign bus.state      = r_state;
  assign bus.hp         = r_hp;
  assign bus.time_left  = w_tmr_count;

endmodule

`default_nettype wire
